// File: rtl/pantalla_fb.sv
// Page-organised monochrome framebuffer: pixel read-modify-write port,
// page-byte refresh read port and a whole-screen fill engine.
module pantalla_fb #(
  parameter int COLS = 128,
  parameter int ROWS = 64,
  parameter int CW   = 7,
  parameter int RW   = 6,
  parameter int PW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  output logic             wr_ready,
  input  logic [RW+CW-1:0] addr_wr,
  input  logic             d_in,
  input  logic [1:0]       mode,
  input  logic             rd,
  input  logic [PW+CW-1:0] addr_rd,
  output logic [7:0]       d_out,
  output logic             rd_valid,
  input  logic             fill_start,
  input  logic [7:0]       fill_val,
  output logic             busy,
  output logic             fill_done
);

  localparam int DEPTH = (ROWS / 8) * COLS;
  localparam int AW    = PW + CW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [7:0] mem [0:DEPTH-1];

  // Fill engine state
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    fval_q, fval_d;

  // Pixel write pipeline, stage 1 (old byte arrives from RAM here)
  logic          s1_valid_q;
  logic          s1_ok_q;
  logic [AW-1:0] s1_idx_q;
  logic [2:0]    s1_bit_q;
  logic [1:0]    s1_mode_q;
  logic          s1_din_q;
  logic [7:0]    pix_rdata_q;

  // Last RAM commit, used to forward around the read-before-write RAM
  logic          last_we_q;
  logic [AW-1:0] last_idx_q;
  logic [7:0]    last_data_q;

  // Refresh read port
  logic          rd_valid_q;
  logic          rd_ok_q;
  logic [AW-1:0] rd_idx_q;
  logic [7:0]    rd_rdata_q;
  logic [7:0]    d_out_q;
  logic [7:0]    rd_byte;

  logic [CW-1:0] wcol;
  logic [RW-1:0] wrow;
  logic [AW-1:0] widx;
  logic          w_ok;
  logic          r_ok;
  logic          wr_acc;

  logic [7:0]    old_byte;
  logic          old_bit;
  logic          new_bit;
  logic [7:0]    merged;

  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [7:0]    mem_wdata;

  assign wcol = addr_wr[CW-1:0];
  assign wrow = addr_wr[RW+CW-1:CW];
  assign widx = {wrow[RW-1:3], wcol};
  assign w_ok = ({1'b0, wcol} < (CW+1)'(COLS)) && ({1'b0, wrow} < (RW+1)'(ROWS));
  assign r_ok = ({1'b0, addr_rd[AW-1:CW]} < (PW+1)'(ROWS / 8)) &&
                ({1'b0, addr_rd[CW-1:0]} < (CW+1)'(COLS));

  assign busy      = (state_q == ST_DRAIN) || (state_q == ST_FILL);
  assign fill_done = (state_q == ST_DONE);
  assign wr_ready  = ~busy & ~fill_start;
  assign wr_acc    = wr & wr_ready;
  assign rd_valid  = rd_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fval_d  = fval_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (fill_start) begin
          state_d = ST_DRAIN;
          fval_d  = fill_val;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: state_d = ST_FILL;
      ST_FILL: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Old byte comes from the commit one cycle back when it hit the same byte.
  always_comb begin
    old_byte = (last_we_q && (last_idx_q == s1_idx_q)) ? last_data_q : pix_rdata_q;
    old_bit  = old_byte[s1_bit_q];
    case (s1_mode_q)
      2'b00:   new_bit = s1_din_q;
      2'b01:   new_bit = old_bit | s1_din_q;
      2'b10:   new_bit = old_bit & ~s1_din_q;
      default: new_bit = old_bit ^ s1_din_q;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi] = (s1_bit_q == 3'(gi)) ? new_bit : old_byte[gi];
    end
  endgenerate

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = s1_idx_q;
    mem_wdata = merged;
    if (state_q == ST_FILL) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_wdata = fval_q;
    end else if (s1_valid_q && s1_ok_q) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    if (!rd_ok_q) begin
      rd_byte = 8'h00;
    end else if (last_we_q && (last_idx_q == rd_idx_q)) begin
      rd_byte = last_data_q;
    end else begin
      rd_byte = rd_rdata_q;
    end
    d_out = rd_valid_q ? rd_byte : d_out_q;
  end

  // RAM array and its registered read ports; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
    if (wr_acc) begin
      pix_rdata_q <= mem[widx];
    end
    if (rd) begin
      rd_rdata_q <= mem[addr_rd];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fval_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_idx_q    <= '0;
      s1_bit_q    <= '0;
      s1_mode_q   <= '0;
      s1_din_q    <= 1'b0;
      last_we_q   <= 1'b0;
      last_idx_q  <= '0;
      last_data_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_ok_q     <= 1'b0;
      rd_idx_q    <= '0;
      d_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fval_q      <= fval_d;
      s1_valid_q  <= wr_acc;
      if (wr_acc) begin
        s1_ok_q   <= w_ok;
        s1_idx_q  <= widx;
        s1_bit_q  <= wrow[2:0];
        s1_mode_q <= mode;
        s1_din_q  <= d_in;
      end
      last_we_q   <= mem_we;
      last_idx_q  <= mem_widx;
      last_data_q <= mem_wdata;
      rd_valid_q  <= rd;
      if (rd) begin
        rd_ok_q  <= r_ok;
        rd_idx_q <= addr_rd;
      end
      d_out_q     <= d_out;
    end
  end

endmodule

// File: tb/tb_pantalla_fb.sv
// Directed bench for pantalla_fb: fill engine timing, pixel plot modes,
// write/read coherency, reads during fill, fill abort and start collisions.
module tb_pantalla_fb;

  logic        clk;
  logic        rst;
  logic        wr;
  logic        wr_ready;
  logic [12:0] addr_wr;
  logic        d_in;
  logic [1:0]  mode;
  logic        rd;
  logic [9:0]  addr_rd;
  logic [7:0]  d_out;
  logic        rd_valid;
  logic        fill_start;
  logic [7:0]  fill_val;
  logic        busy;
  logic        fill_done;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  hold   = 8'h00;

  pantalla_fb dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .wr_ready   (wr_ready),
    .addr_wr    (addr_wr),
    .d_in       (d_in),
    .mode       (mode),
    .rd         (rd),
    .addr_rd    (addr_rd),
    .d_out      (d_out),
    .rd_valid   (rd_valid),
    .fill_start (fill_start),
    .fill_val   (fill_val),
    .busy       (busy),
    .fill_done  (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [5:0] row;
    logic [6:0] col;
    logic [1:0] mode;
    logic       din;
    logic       rd;
    logic [2:0] page;
    logic [6:0] rcol;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mkw(input logic [5:0] row, input logic [6:0] col,
                               input logic [1:0] md, input logic din);
    vec_t v;
    v = '{1'b1, row, col, md, din, 1'b0, 3'd0, 7'd0, 8'h00};
    return v;
  endfunction

  function automatic vec_t mkr(input logic [2:0] page, input logic [6:0] col,
                               input logic [7:0] exp);
    vec_t v;
    v = '{1'b0, 6'd0, 7'd0, 2'd0, 1'b0, 1'b1, page, col, exp};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [2:0] p, input logic [6:0] c,
                          input logic [7:0] exp);
    rd = 1'b1;
    addr_rd = {p, c};
    @(posedge clk); #1;
    rd = 1'b0;
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk(name, 32'(d_out), 32'(exp));
    hold = exp;
    $display("read  %-18s page=%0d col=%0d d_out=0x%02h", name, p, c, d_out);
  endtask

  // Runs from the DRAIN sample point through the end of a fill; optionally
  // pulses fill_start (with a different value) at sample point extra_n.
  task automatic fill_watch(input int extra_n, output int bc, output int dp, output int ov);
    logic [7:0] v;
    v = fill_val;
    bc = 0; dp = 0; ov = 0;
    for (int n = 0; n < 1032; n++) begin
      if (busy) bc++;
      if (fill_done) begin
        dp++;
        if (busy) ov++;
      end
      if (n == extra_n) begin
        fill_start = 1'b1;
        fill_val = ~v;
      end else begin
        fill_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    fill_start = 1'b0;
  endtask

  initial begin
    int bc, dp, ov, acc_n, blocked, done_at_acc;

    rst = 1'b1; wr = 1'b0; addr_wr = '0; d_in = 1'b0; mode = 2'd0;
    rd = 1'b0; addr_rd = '0; fill_start = 1'b0; fill_val = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);

    // Clear the screen with fill 0x00
    fill_val = 8'h00; fill_start = 1'b1; #1;
    chk("start_blocks_wr", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    fill_start = 1'b0;
    fill_watch(-1, bc, dp, ov);
    $display("fill  0x00 busy_cycles=%0d done_pulses=%0d", bc, dp);
    chk("fill0_busy_len", 32'(bc), 32'd1025);
    chk("fill0_done_pulses", 32'(dp), 32'd1);
    chk("fill0_done_busy_overlap", 32'(ov), 32'd0);
    rd_check("fill0_p0c0", 3'd0, 7'd0, 8'h00);
    rd_check("fill0_p7c127", 3'd7, 7'd127, 8'h00);

    // Plot-mode vectors, one per cycle
    vecs[0]  = mkw(6'd10, 7'd5, 2'b00, 1'b1);
    vecs[1]  = mkr(3'd1, 7'd5, 8'h04);
    vecs[2]  = mkw(6'd10, 7'd5, 2'b11, 1'b1);
    vecs[3]  = mkr(3'd1, 7'd5, 8'h00);
    for (int i = 0; i < 8; i++) vecs[4+i] = mkw(6'(16 + i), 7'd3, 2'b01, 1'b1);
    vecs[12] = mkr(3'd2, 7'd3, 8'hFF);
    vecs[13] = mkw(6'd20, 7'd3, 2'b10, 1'b1);
    vecs[14] = mkr(3'd2, 7'd3, 8'hEF);
    vecs[15] = mkw(6'd0, 7'd0, 2'b00, 1'b1);
    vecs[16] = mkw(6'd1, 7'd0, 2'b01, 1'b1);
    vecs[17] = mkw(6'd0, 7'd0, 2'b11, 1'b1);
    vecs[18] = mkw(6'd7, 7'd0, 2'b00, 1'b1);
    vecs[19] = mkr(3'd0, 7'd0, 8'h82);
    vecs[20] = mkw(6'd63, 7'd127, 2'b00, 1'b1);
    vecs[21] = mkr(3'd7, 7'd127, 8'h80);
    vecs[22] = mkw(6'd16, 7'd3, 2'b10, 1'b0);
    vecs[23] = mkr(3'd2, 7'd3, 8'hEF);
    vecs[24] = mkw(6'd21, 7'd3, 2'b11, 1'b0);
    vecs[25] = mkr(3'd2, 7'd3, 8'hEF);
    vecs[26] = mkr(3'd7, 7'd126, 8'h00);
    vecs[27] = '{1'b0, 6'd0, 7'd0, 2'd0, 1'b0, 1'b0, 3'd0, 7'd0, 8'h00};

    for (int i = 0; i < NV; i++) begin
      wr = vecs[i].wr;
      addr_wr = {vecs[i].row, vecs[i].col};
      mode = vecs[i].mode;
      d_in = vecs[i].din;
      rd = vecs[i].rd;
      addr_rd = {vecs[i].page, vecs[i].rcol};
      @(posedge clk); #1;
      wr = 1'b0;
      rd = 1'b0;
      if (vecs[i].rd) hold = vecs[i].exp;
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_d_out", i), 32'(d_out), 32'(hold));
      $display("vec%0d wr=%0d row=%0d col=%0d mode=%0d d=%0d rd=%0d page=%0d col=%0d d_out=0x%02h",
               i, vecs[i].wr, vecs[i].row, vecs[i].col, vecs[i].mode, vecs[i].din,
               vecs[i].rd, vecs[i].page, vecs[i].rcol, d_out);
    end

    // Fill 0xA5 with reads during the fill and a pixel write held throughout
    fill_val = 8'hA5; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
    wr = 1'b1; addr_wr = {6'd0, 7'd0}; mode = 2'b00; d_in = 1'b0;
    acc_n = -1; blocked = 0; done_at_acc = 0; bc = 0; dp = 0;
    for (int n = 0; n < 1032; n++) begin
      if (n == 4)    chk("fillA5_early_read", 32'(d_out), 32'hA5);
      if (n == 5)    chk("fillA5_unfilled_read", 32'(d_out), 32'hEF);
      if (n == 1002) chk("fillA5_late_filled", 32'(d_out), 32'hA5);
      if (n == 1003) chk("fillA5_late_unfilled", 32'(d_out), 32'h80);
      if (n == 1027) chk("held_wr_result", 32'(d_out), 32'hA4);
      if (busy) bc++;
      if (fill_done) dp++;
      if (busy && wr_ready) blocked++;
      if (acc_n >= 0) wr = 1'b0;
      if (wr && wr_ready && acc_n < 0) begin
        acc_n = n;
        done_at_acc = int'(fill_done);
      end
      rd = 1'b0;
      case (n)
        3:    begin rd = 1'b1; addr_rd = {3'd0, 7'd1};   end
        4:    begin rd = 1'b1; addr_rd = {3'd2, 7'd3};   end
        1001: begin rd = 1'b1; addr_rd = {3'd7, 7'd103}; end
        1002: begin rd = 1'b1; addr_rd = {3'd7, 7'd127}; end
        1026: begin rd = 1'b1; addr_rd = {3'd0, 7'd0};   end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    rd = 1'b0; wr = 1'b0;
    hold = 8'hA4;
    $display("fill  0xA5 busy_cycles=%0d done_pulses=%0d wr_accepted_at=%0d", bc, dp, acc_n);
    chk("fillA5_busy_len", 32'(bc), 32'd1025);
    chk("fillA5_done_pulses", 32'(dp), 32'd1);
    chk("fillA5_wr_blocked", 32'(blocked), 32'd0);
    chk("fillA5_wr_accept_cycle", 32'(acc_n), 32'd1025);
    chk("fillA5_wr_accept_on_done", 32'(done_at_acc), 32'd1);

    // Reset in the middle of a fill (fill cycle 300)
    fill_val = 8'h3C; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
    for (int n = 0; n < 301; n++) begin
      @(posedge clk); #1;
    end
    chk("prerst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fill_done", 32'(fill_done), 32'd0);
    chk("midrst_d_out", 32'(d_out), 32'd0);
    hold = 8'h00;
    dp = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (fill_done || busy) dp++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fill_done || busy) dp++;
    end
    $display("abort fill 0x3C stray_busy_or_done=%0d", dp);
    chk("abort_no_activity", 32'(dp), 32'd0);
    rd_check("abort_byte299", 3'd2, 7'd43, 8'h3C);
    rd_check("abort_byte301", 3'd2, 7'd45, 8'hA5);

    // fill_start and wr together, then a fill_start while busy
    fill_val = 8'h00; fill_start = 1'b1;
    wr = 1'b1; addr_wr = {6'd40, 7'd9}; mode = 2'b00; d_in = 1'b1;
    #1;
    chk("collide_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    fill_start = 1'b0;
    wr = 1'b0;
    fill_watch(500, bc, dp, ov);
    $display("fill  0x00 with restart attempt busy_cycles=%0d done_pulses=%0d", bc, dp);
    chk("restart_busy_len", 32'(bc), 32'd1025);
    chk("restart_done_pulses", 32'(dp), 32'd1);
    chk("restart_done_busy_overlap", 32'(ov), 32'd0);
    rd_check("collide_pixel", 3'd5, 7'd9, 8'h00);
    rd_check("restart_last_byte", 3'd7, 7'd127, 8'h00);
    rd_check("restart_byte301", 3'd2, 7'd45, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
